mem_port_req_ctrl: RTL and testbench

Single-clock request front-end for one port of the dual-port latency memory. It accepts valid/ready read/write requests, drives the memory port's enable/write/address/data pins, tracks read data across the memory's fixed read latency, and buffers returned data in an in-order response FIFO. Credit accounting guarantees the FIFO never overflows, so memory read data is never dropped under downstream backpressure.

---
 rtl/mem_port_pkg.sv | 19 +
 rtl/mem_rsp_fifo.sv | 73 +++++++
 rtl/mem_port_req_ctrl.sv | 130 +++++++++++++
 tb/tb_mem_port_req_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_pkg.sv
// Shared types for the memory port request front-end: response FIFO entry and credit width.
// MEM_PORT_REQ_CTRL_WR_ACK_EN adds the is_wr flag to each response entry.
package mem_port_pkg;

    // Response data width; the controller's WIDTH parameter must equal this.
    localparam int RSP_DATA_W = 8;

    typedef struct packed {
`ifdef MEM_PORT_REQ_CTRL_WR_ACK_EN
        logic                  is_wr;
`endif
        logic [RSP_DATA_W-1:0] data;
    } rsp_entry_t;

    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/mem_rsp_fifo.sv
// Synchronous in-order FIFO for memory responses; pointers wrap modulo DEPTH (any DEPTH >= 2).
// Pushing while full is only legal together with a pop.
module mem_rsp_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [7:0]
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  T                           i_push_data,
    input  logic                       i_pop,
    output T                           o_head,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    T              mem_q [DEPTH];
    T              mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pop_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_empty = (count_q == '0);
    assign o_full  = (count_q == CW'(DEPTH));
    assign o_count = count_q;
    assign o_head  = o_empty ? '0 : mem_q[rd_ptr_q];
    assign pop_ok  = i_pop & ~o_empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_push) begin
            mem_d[wr_ptr_q] = i_push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop_ok) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (i_push && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (!i_push && pop_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible through count/pointers.
    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/mem_port_req_ctrl.sv
// Request front-end for one memory port: valid/ready issue, fixed-latency read tracking and
// credit-protected response FIFO. MEM_PORT_REQ_CTRL_WR_ACK_EN turns on write acknowledges.
module mem_port_req_ctrl
    import mem_port_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int ADDR_WIDTH   = 4,
    parameter int READ_LATENCY = 2,
    parameter int RSP_DEPTH    = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [WIDTH-1:0]      i_req_din,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [WIDTH-1:0]      o_rsp_data,
`ifdef MEM_PORT_REQ_CTRL_WR_ACK_EN
    output logic                  o_rsp_is_wr,
`endif
    output logic                  o_mem_en,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [WIDTH-1:0]      o_mem_din,
    input  logic [WIDTH-1:0]      i_mem_dout,
    output logic                  o_busy
);
    localparam int CW = credit_width(RSP_DEPTH);

    logic                    fire;
    logic                    issue;
    logic [READ_LATENCY-1:0] vld_q, vld_d;
    logic                    retire;
    logic [CW-1:0]           inflight;
    logic [CW-1:0]           outstanding;
    logic [CW-1:0]           rsp_count;
    logic                    rsp_full;
    logic                    rsp_empty;
    logic                    rsp_push;
    logic                    rsp_pop;
    rsp_entry_t              push_entry;
    rsp_entry_t              head;

    assign fire       = i_req_valid & o_req_ready;
    assign o_mem_en   = fire;
    assign o_mem_we   = fire & i_req_we;
    assign o_mem_addr = i_req_addr;
    assign o_mem_din  = i_req_din;

`ifdef MEM_PORT_REQ_CTRL_WR_ACK_EN
    logic [READ_LATENCY-1:0] wr_q, wr_d;

    assign issue = fire;

    always_comb begin
        wr_d    = '0;
        wr_d[0] = i_req_we;
        for (int i = 1; i < READ_LATENCY; i++) wr_d[i] = wr_q[i-1];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) wr_q <= '0;
        else       wr_q <= wr_d;
    end

    always_comb begin
        push_entry       = '0;
        push_entry.is_wr = wr_q[READ_LATENCY-1];
        push_entry.data  = wr_q[READ_LATENCY-1] ? '0 : RSP_DATA_W'(i_mem_dout);
    end

    assign o_rsp_is_wr = head.is_wr;
`else
    assign issue = fire & ~i_req_we;

    always_comb begin
        push_entry      = '0;
        push_entry.data = RSP_DATA_W'(i_mem_dout);
    end
`endif

    // Bit k set means a tracked request was issued k+1 edges ago.
    always_comb begin
        vld_d    = '0;
        vld_d[0] = issue;
        for (int i = 1; i < READ_LATENCY; i++) vld_d[i] = vld_q[i-1];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) vld_q <= '0;
        else       vld_q <= vld_d;
    end

    assign retire = vld_q[READ_LATENCY-1];

    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + CW'(vld_q[i]);
    end

    // Credit is taken from registered state only, so a pop frees a slot the following cycle.
    assign outstanding = inflight + rsp_count;
    assign o_req_ready = ~i_rst & (outstanding < CW'(RSP_DEPTH));
    assign o_busy      = (outstanding != '0);

    assign rsp_pop  = ~rsp_empty & i_rsp_ready;
    assign rsp_push = retire & (~rsp_full | rsp_pop);

    mem_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .T     (rsp_entry_t)
    ) u_rsp_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (rsp_push),
        .i_push_data (push_entry),
        .i_pop       (rsp_pop),
        .o_head      (head),
        .o_full      (rsp_full),
        .o_empty     (rsp_empty),
        .o_count     (rsp_count)
    );

    assign o_rsp_valid = ~rsp_empty;
    assign o_rsp_data  = WIDTH'(head.data);

endmodule

// File: tb/tb_mem_port_req_ctrl.sv
// Directed bench for mem_port_req_ctrl with a READ_LATENCY=2 memory model attached.
module tb_mem_port_req_ctrl;
    localparam int W  = 8;
    localparam int AW = 4;

`ifdef MEM_PORT_REQ_CTRL_WR_ACK_EN
    localparam logic ACK = 1'b1;
`else
    localparam logic ACK = 1'b0;
`endif

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_req_valid;
    logic          o_req_ready;
    logic          i_req_we;
    logic [AW-1:0] i_req_addr;
    logic [W-1:0]  i_req_din;
    logic          o_rsp_valid;
    logic          i_rsp_ready;
    logic [W-1:0]  o_rsp_data;
    logic          o_mem_en;
    logic          o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [W-1:0]  o_mem_din;
    logic [W-1:0]  i_mem_dout;
    logic          o_busy;
`ifdef MEM_PORT_REQ_CTRL_WR_ACK_EN
    logic          o_rsp_is_wr;
`endif

    int tests = 0;
    int fails = 0;
    int acc;

    always #5 i_clk = ~i_clk;

    mem_port_req_ctrl #(
        .WIDTH(W), .ADDR_WIDTH(AW), .READ_LATENCY(2), .RSP_DEPTH(4)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_we    (i_req_we),
        .i_req_addr  (i_req_addr),
        .i_req_din   (i_req_din),
        .o_rsp_valid (o_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .o_rsp_data  (o_rsp_data),
`ifdef MEM_PORT_REQ_CTRL_WR_ACK_EN
        .o_rsp_is_wr (o_rsp_is_wr),
`endif
        .o_mem_en    (o_mem_en),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_din   (o_mem_din),
        .i_mem_dout  (i_mem_dout),
        .o_busy      (o_busy)
    );

    // Memory port: address sampled at edge t, data on dout during the cycle ending at t+2.
    bit [W-1:0] mem [16];
    bit [W-1:0] rd_s1, rd_s2;
    always @(posedge i_clk) begin
        if (o_mem_en && o_mem_we)  mem[o_mem_addr] <= o_mem_din;
        if (o_mem_en && !o_mem_we) rd_s1 <= mem[o_mem_addr];
        rd_s2 <= rd_s1;
    end
    assign i_mem_dout = rd_s2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1'b1; i_req_valid = 1'b1; i_req_we = 1'b1;
        i_req_addr = 4'd3; i_req_din = 8'hA5; i_rsp_ready = 1'b0;
        tick(); tick();
        chk("rst_ready",     o_req_ready, 0);
        chk("rst_mem_en",    o_mem_en,    0);
        chk("rst_mem_we",    o_mem_we,    0);
        chk("rst_rsp_valid", o_rsp_valid, 0);
        chk("rst_rsp_data",  o_rsp_data,  0);
        chk("rst_busy",      o_busy,      0);

        // Write addr 3 = 0xA5, idle two cycles, then read it back.
        i_rst = 1'b0; i_rsp_ready = 1'b1; #1;
        chk("ready_after_rst", o_req_ready, 1);
        chk("wr_mem_en",   o_mem_en,   1);
        chk("wr_mem_we",   o_mem_we,   1);
        chk("wr_mem_addr", o_mem_addr, 4'd3);
        chk("wr_mem_din",  o_mem_din,  8'hA5);
        tick();
        i_req_valid = 1'b0;
        chk("wr_busy", o_busy, ACK);
        tick(); tick();
        i_req_valid = 1'b1; i_req_we = 1'b0; i_req_addr = 4'd3; #1;
        chk("rd_mem_we", o_mem_we, 0);
        tick();
        i_req_valid = 1'b0;
        chk("raw_t1_valid", o_rsp_valid, 0);
        chk("raw_t1_busy",  o_busy,      1);
        tick();
        chk("raw_t2_valid", o_rsp_valid, 0);
        tick();
        chk("raw_t3_valid", o_rsp_valid, 1);
        chk("raw_t3_data",  o_rsp_data,  8'hA5);
        tick();
        chk("raw_t4_valid", o_rsp_valid, 0);
        chk("raw_t4_busy",  o_busy,      0);

        // Preload addr 0..3 with 0x10..0x13.
        for (int k = 0; k < 4; k++) begin
            i_req_valid = 1'b1; i_req_we = 1'b1;
            i_req_addr = 4'(k); i_req_din = 8'(8'h10 + k);
            tick();
        end
        i_req_valid = 1'b0;
        tick(); tick(); tick(); tick();
        chk("preload_idle_busy", o_busy, 0);

        // Back-to-back reads with the response side always ready.
        for (int k = 0; k < 6; k++) begin
            i_req_valid = (k < 4); i_req_we = 1'b0; i_req_addr = 4'(k); #1;
            chk("b2b_ready", o_req_ready, 1);
            tick();
            if (k >= 2) begin
                chk("b2b_valid", o_rsp_valid, 1);
                chk("b2b_data",  o_rsp_data,  32'h10 + 32'(k - 2));
            end else begin
                chk("b2b_valid_early", o_rsp_valid, 0);
            end
        end
        i_req_valid = 1'b0;
        tick();
        chk("b2b_drained_valid", o_rsp_valid, 0);
        chk("b2b_drained_busy",  o_busy,      0);

        // Backpressure: 6 read attempts, only 4 credits.
        i_rsp_ready = 1'b0; acc = 0;
        for (int k = 0; k < 8; k++) begin
            i_req_valid = (k < 6); i_req_we = 1'b0; i_req_addr = 4'(acc); #1;
            if (i_req_valid && o_req_ready) acc++;
            tick();
        end
        i_req_valid = 1'b0;
        chk("bp_accepts", acc,         4);
        chk("bp_ready",   o_req_ready, 0);
        chk("bp_valid",   o_rsp_valid, 1);
        chk("bp_head",    o_rsp_data,  8'h10);
        chk("bp_busy",    o_busy,      1);
        i_rsp_ready = 1'b1;
        tick();
        chk("bp_ready_after_pop", o_req_ready, 1);
        chk("bp_data1", o_rsp_data, 8'h11);
        tick();
        chk("bp_data2", o_rsp_data, 8'h12);
        tick();
        chk("bp_data3", o_rsp_data, 8'h13);
        tick();
        chk("bp_empty", o_rsp_valid, 0);

        // Last read retires on the same edge as the first pop.
        i_rsp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            i_req_valid = 1'b1; i_req_we = 1'b0; i_req_addr = 4'(k);
            tick();
        end
        i_req_valid = 1'b0;
        tick();
        chk("pp_ready_full", o_req_ready, 0);
        chk("pp_head",       o_rsp_data,  8'h10);
        i_rsp_ready = 1'b1;
        tick();
        chk("pp_data1", o_rsp_data,  8'h11);
        chk("pp_ready", o_req_ready, 1);
        tick();
        chk("pp_data2", o_rsp_data, 8'h12);
        tick();
        chk("pp_data3", o_rsp_data, 8'h13);
        tick();
        chk("pp_empty", o_rsp_valid, 0);
        chk("pp_busy",  o_busy,      0);

        // Reset with 2 reads in flight and 2 queued responses.
        i_rsp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            i_req_valid = 1'b1; i_req_we = 1'b0; i_req_addr = 4'(k);
            tick();
        end
        i_req_valid = 1'b0;
        chk("mr_pre_head", o_rsp_data, 8'h10);
        chk("mr_pre_busy", o_busy,     1);
        i_rst = 1'b1; #1;
        chk("mr_ready_in_rst", o_req_ready, 0);
        tick();
        chk("mr_valid", o_rsp_valid, 0);
        chk("mr_busy",  o_busy,      0);
        chk("mr_data",  o_rsp_data,  0);
        i_rst = 1'b0; i_rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("mr_no_stale", o_rsp_valid, 0);
        end

`ifdef MEM_PORT_REQ_CTRL_WR_ACK_EN
        // Write then read: ack entry precedes read data, both hold credit.
        i_rsp_ready = 1'b0;
        i_req_valid = 1'b1; i_req_we = 1'b1; i_req_addr = 4'd9; i_req_din = 8'h77;
        tick();
        i_req_we = 1'b0; i_req_addr = 4'd0;
        tick();
        i_req_valid = 1'b0;
        chk("ack_busy", o_busy, 1);
        tick();
        chk("ack_valid", o_rsp_valid, 1);
        chk("ack_is_wr", o_rsp_is_wr, 1);
        chk("ack_data",  o_rsp_data,  0);
        tick();
        i_rsp_ready = 1'b1;
        tick();
        chk("ack_rd_is_wr", o_rsp_is_wr, 0);
        chk("ack_rd_data",  o_rsp_data,  8'h10);
        tick();
        chk("ack_empty", o_rsp_valid, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
